mux8_rr_arbiter: RTL

- Round-robin arbiter and sequencer for the shared 8:1 bit selector.
- Up to 8 requesters contend for the selector. The block grants exactly one requester at a time and drives the 3-bit select for the granted channel.
- It registers the selected data bit for the current owner.
- It sits between the requester logic and the combinational 8:1 mux, so the mux never sees select changes mid-transfer.

---
 rtl/mux8_rr_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner sequencer for a shared 8:1 bit selector: grants, drives sel, samples data.
// Optional forced release after MAX_HOLD BUSY cycles when MUX8_ARB_TIMEOUT_EN is defined.
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD  = 16,
    parameter int unsigned PTR_RESET = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    input  logic [7:0] data_in,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       data_out,
    output logic       data_vld
);
    localparam int unsigned N_CH  = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux8_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] sel_nxt;
    logic [N_CH-1:0]  grant_nxt;
    logic             busy_nxt;
    logic             data_out_nxt;
    logic             data_vld_nxt;
    logic             timeout_c;
    logic             exit_c;

`ifdef MUX8_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;

    assign timeout_c = (hold_cnt == HOLD_LAST);
`else
    assign timeout_c = 1'b0;
`endif

    assign exit_c = (state == BUSY) && (done || !req[sel] || timeout_c);

    // First requester strictly after the last owner, wrapping mod 8
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            data_out <= 1'b0;
            data_vld <= 1'b0;
            ptr      <= IDX_W'(PTR_RESET);
`ifdef MUX8_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
            busy     <= busy_nxt;
            data_out <= data_out_nxt;
            data_vld <= data_vld_nxt;
            ptr      <= ptr_nxt;
`ifdef MUX8_ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt_nxt;
`endif
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = BUSY;
            BUSY:    if (exit_c) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; GAP lets data_vld fall after one cycle
    always_comb begin
        grant_nxt    = grant;
        sel_nxt      = sel;
        busy_nxt     = busy;
        data_out_nxt = data_out;
        data_vld_nxt = 1'b0;
        ptr_nxt      = ptr;
`ifdef MUX8_ARB_TIMEOUT_EN
        hold_cnt_nxt = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_nxt = N_CH'(1) << winner;
                    sel_nxt   = winner;
                    ptr_nxt   = winner;
                    busy_nxt  = 1'b1;
`ifdef MUX8_ARB_TIMEOUT_EN
                    hold_cnt_nxt = '0;
`endif
                end
            end
            BUSY: begin
                data_out_nxt = data_in[sel];
                data_vld_nxt = 1'b1;
`ifdef MUX8_ARB_TIMEOUT_EN
                if (hold_cnt != '1) hold_cnt_nxt = hold_cnt + CNT_W'(1);
`endif
                if (exit_c) begin
                    grant_nxt = '0;
                    busy_nxt  = 1'b0;
                end
            end
            GAP: begin
                grant_nxt = '0;
                busy_nxt  = 1'b0;
            end
            default: begin
                grant_nxt = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
